// File: rtl/cube_color_tracker.sv
// Tracks which pyramid cube tops Q*bert has changed and derives lit count, change pulse and win flag.
// Latency: done_move at cycle t updates outputs at t+SAMPLE_DLY+2; start clears outputs at s+1.
// No backpressure: done_move arriving while a sample is pending is dropped; a paused move is held in pend.
module cube_color_tracker #(
    parameter int N_CUBE     = 28,
    parameter int MODE       = 0,
    parameter int SAMPLE_DLY = 2
) (
    input  logic              CLK_33,
    input  logic              reset,
    input  logic              e_start_qb,
    input  logic              e_pause_qb,
    input  logic              done_move,
    input  logic [N_CUBE-1:0] position_qb,
    output logic [N_CUBE-1:0] color_state,
    output logic [4:0]        lit_count,
    output logic              cube_changed,
    output logic [4:0]        cube_idx,
    output logic              win,
    output logic              pos_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DELAY = 3'd2,
        APPLY = 3'd3,
        WIN   = 3'd4
    } state_t;

    localparam logic [4:0] LIT_MAX  = 5'(N_CUBE);
    localparam logic [3:0] DLY_LOAD = 4'(SAMPLE_DLY);

    state_t     state;
    logic       pend;
    logic [3:0] dly_cnt;

    // Position decode: presence, multiplicity and binary index of the set bit(s).
    logic       pos_any;
    logic       pos_many;
    logic [4:0] pos_bin;
    logic       pos_ok;

    // Landing outcome for the sampled position.
    logic       hit;
    logic       apply_flip;
    logic [4:0] apply_cnt;

    // Decode the one-hot position into a binary index and flag malformed vectors.
    always_comb begin
        pos_any  = 1'b0;
        pos_many = 1'b0;
        pos_bin  = '0;
        for (int i = 0; i < N_CUBE; i++) begin
            if (position_qb[i]) begin
                pos_many = pos_many | pos_any;
                pos_any  = 1'b1;
                pos_bin  = pos_bin | 5'(i);
            end
        end
        pos_ok = pos_any & ~pos_many;
    end

    // Work out whether this landing changes the cube and what the lit count becomes (saturating).
    always_comb begin
        hit        = color_state[pos_bin];
        apply_flip = pos_ok & ((MODE != 0) | ~hit);
        apply_cnt  = lit_count;
        if (apply_flip) begin
            if (hit) begin
                apply_cnt = (lit_count == 5'd0) ? 5'd0 : lit_count - 5'd1;
            end else begin
                apply_cnt = (lit_count >= LIT_MAX) ? LIT_MAX : lit_count + 5'd1;
            end
        end
    end

    // Control FSM with registered outputs; start has priority over every other event.
    always_ff @(posedge CLK_33) begin
        if (reset) begin
            state        <= IDLE;
            pend         <= 1'b0;
            dly_cnt      <= '0;
            color_state  <= '0;
            lit_count    <= '0;
            cube_changed <= 1'b0;
            cube_idx     <= '0;
            win          <= 1'b0;
            pos_err      <= 1'b0;
        end else begin
            cube_changed <= 1'b0;
            pos_err      <= 1'b0;
            if (e_start_qb) begin
                state       <= RUN;
                pend        <= 1'b0;
                dly_cnt     <= '0;
                color_state <= '0;
                lit_count   <= '0;
                cube_idx    <= '0;
                win         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // Waiting for a level start; moves are ignored.
                    end
                    RUN: begin
                        if ((done_move || pend) && !e_pause_qb) begin
                            pend    <= 1'b0;
                            dly_cnt <= DLY_LOAD;
                            state   <= DELAY;
                        end else if (done_move) begin
                            pend <= 1'b1;
                        end
                    end
                    DELAY: begin
                        // Keeps counting through a pause so the sample point stays fixed.
                        if (dly_cnt <= 4'd1) begin
                            dly_cnt <= '0;
                            state   <= APPLY;
                        end else begin
                            dly_cnt <= dly_cnt - 4'd1;
                        end
                    end
                    APPLY: begin
                        if (!pos_ok) begin
                            pos_err <= 1'b1;
                        end
                        if (apply_flip) begin
                            color_state[pos_bin] <= ~hit;
                            cube_changed         <= 1'b1;
                            cube_idx             <= pos_bin;
                        end
                        lit_count <= apply_cnt;
                        if (apply_cnt == LIT_MAX) begin
                            win   <= 1'b1;
                            state <= WIN;
                        end else begin
                            state <= RUN;
                        end
                    end
                    WIN: begin
                        // Board frozen until the next start or reset.
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cube_color_tracker.sv
// Bench for cube_color_tracker: one set-only and one toggle instance share all inputs.
// Directed table, hand-written corner sequences, then random landings against a cube-array model.
module tb_cube_color_tracker;

    logic        clk = 1'b0;
    logic        reset, e_start_qb, e_pause_qb, done_move;
    logic [27:0] position_qb;

    logic [27:0] cs0, cs1;
    logic [4:0]  lc0, lc1, ix0, ix1;
    logic        ch0, ch1, w0, w1, pe0, pe1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cube_color_tracker #(.N_CUBE(28), .MODE(0), .SAMPLE_DLY(2)) u_m0 (
        .CLK_33(clk), .reset(reset), .e_start_qb(e_start_qb), .e_pause_qb(e_pause_qb),
        .done_move(done_move), .position_qb(position_qb), .color_state(cs0),
        .lit_count(lc0), .cube_changed(ch0), .cube_idx(ix0), .win(w0), .pos_err(pe0));

    cube_color_tracker #(.N_CUBE(28), .MODE(1), .SAMPLE_DLY(2)) u_m1 (
        .CLK_33(clk), .reset(reset), .e_start_qb(e_start_qb), .e_pause_qb(e_pause_qb),
        .done_move(done_move), .position_qb(position_qb), .color_state(cs1),
        .lit_count(lc1), .cube_changed(ch1), .cube_idx(ix1), .win(w1), .pos_err(pe1));

    typedef struct {
        logic [27:0] pos;
        logic        chg0;
        logic [4:0]  idx;
        logic [4:0]  lit0;
        logic [27:0] st0;
        logic        chg1;
        logic [4:0]  lit1;
        logic [27:0] st1;
        logic        err;
    } vec_t;

    vec_t tbl[6];

    // Reference model: lit flag per cube for each mode.
    bit m_lit[2][28];
    bit m_win[2];
    bit e_chg[2];
    bit e_err[2];
    int e_idx;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start;
        e_start_qb = 1'b1;
        tick;
        e_start_qb = 1'b0;
    endtask

    // Drive a landing; returns on the cycle its result must be visible.
    task automatic move(input logic [27:0] pos, input bit extra);
        position_qb = pos;
        done_move   = 1'b1;
        tick;
        done_move   = extra;
        tick;
        done_move   = 1'b0;
        tick;
        chk("early_update", {30'd0, ch0, ch1}, 32'd0);
        tick;
    endtask

    function automatic logic [27:0] pack(input int k);
        logic [27:0] v;
        v = '0;
        for (int i = 0; i < 28; i++) v[i] = m_lit[k][i];
        return v;
    endfunction

    function automatic int lit_sum(input int k);
        int s;
        s = 0;
        for (int i = 0; i < 28; i++) s += int'(m_lit[k][i]);
        return s;
    endfunction

    task automatic model_clear;
        for (int k = 0; k < 2; k++) begin
            m_win[k] = 0;
            for (int i = 0; i < 28; i++) m_lit[k][i] = 0;
        end
    endtask

    // Apply the game rules to one landing: set-only for k=0, toggle for k=1.
    task automatic model_land(input logic [27:0] pos);
        int ones, where;
        ones  = 0;
        where = 0;
        for (int i = 0; i < 28; i++) if (pos[i]) begin ones++; where = i; end
        e_idx = where;
        for (int k = 0; k < 2; k++) begin
            e_chg[k] = 0;
            e_err[k] = 0;
            if (!m_win[k]) begin
                if (ones != 1) e_err[k] = 1;
                else if (k == 1 || !m_lit[k][where]) begin
                    m_lit[k][where] = !m_lit[k][where];
                    e_chg[k] = 1;
                end
                if (lit_sum(k) == 28) m_win[k] = 1;
            end
        end
    endtask

    task automatic chk_model;
        chk("rnd_cs0", {4'd0, cs0}, {4'd0, pack(0)});
        chk("rnd_cs1", {4'd0, cs1}, {4'd0, pack(1)});
        chk("rnd_lc0", {27'd0, lc0}, lit_sum(0));
        chk("rnd_lc1", {27'd0, lc1}, lit_sum(1));
        chk("rnd_ch0", {31'd0, ch0}, {31'd0, e_chg[0]});
        chk("rnd_ch1", {31'd0, ch1}, {31'd0, e_chg[1]});
        chk("rnd_pe0", {31'd0, pe0}, {31'd0, e_err[0]});
        chk("rnd_pe1", {31'd0, pe1}, {31'd0, e_err[1]});
        chk("rnd_w0", {31'd0, w0}, {31'd0, m_win[0]});
        chk("rnd_w1", {31'd0, w1}, {31'd0, m_win[1]});
        if (e_chg[0]) chk("rnd_ix0", {27'd0, ix0}, e_idx);
        if (e_chg[1]) chk("rnd_ix1", {27'd0, ix1}, e_idx);
    endtask

    initial begin
        logic [27:0] p;
        bit          seen;

        tbl[0] = '{28'h0000020, 1'b1, 5'd5,  5'd1, 28'h0000020, 1'b1, 5'd1, 28'h0000020, 1'b0};
        tbl[1] = '{28'h0000020, 1'b0, 5'd5,  5'd1, 28'h0000020, 1'b1, 5'd0, 28'h0000000, 1'b0};
        tbl[2] = '{28'h0000001, 1'b1, 5'd0,  5'd2, 28'h0000021, 1'b1, 5'd1, 28'h0000001, 1'b0};
        tbl[3] = '{28'h0000000, 1'b0, 5'd0,  5'd2, 28'h0000021, 1'b0, 5'd1, 28'h0000001, 1'b1};
        tbl[4] = '{28'h0000003, 1'b0, 5'd0,  5'd2, 28'h0000021, 1'b0, 5'd1, 28'h0000001, 1'b1};
        tbl[5] = '{28'h8000000, 1'b1, 5'd27, 5'd3, 28'h8000021, 1'b1, 5'd2, 28'h8000001, 1'b0};

        reset = 1'b1; e_start_qb = 1'b0; e_pause_qb = 1'b0; done_move = 1'b0; position_qb = '0;
        tick; tick;
        reset = 1'b0;
        chk("rst_cs0", {4'd0, cs0}, 32'd0);
        chk("rst_lc0", {27'd0, lc0}, 32'd0);
        chk("rst_ix0", {27'd0, ix0}, 32'd0);
        chk("rst_flags", {28'd0, ch0, w0, pe0, w1}, 32'd0);

        // IDLE ignores moves.
        move(28'h0000001, 0);
        tick;
        chk("idle_cs0", {4'd0, cs0}, 32'd0);

        // Directed table.
        pulse_start;
        for (int v = 0; v < 6; v++) begin
            move(tbl[v].pos, 0);
            chk($sformatf("t%0d_ch0", v), {31'd0, ch0}, {31'd0, tbl[v].chg0});
            chk($sformatf("t%0d_ch1", v), {31'd0, ch1}, {31'd0, tbl[v].chg1});
            chk($sformatf("t%0d_cs0", v), {4'd0, cs0}, {4'd0, tbl[v].st0});
            chk($sformatf("t%0d_cs1", v), {4'd0, cs1}, {4'd0, tbl[v].st1});
            chk($sformatf("t%0d_lc0", v), {27'd0, lc0}, {27'd0, tbl[v].lit0});
            chk($sformatf("t%0d_lc1", v), {27'd0, lc1}, {27'd0, tbl[v].lit1});
            chk($sformatf("t%0d_pe", v), {30'd0, pe0, pe1}, {30'd0, tbl[v].err, tbl[v].err});
            if (tbl[v].chg0) chk($sformatf("t%0d_ix0", v), {27'd0, ix0}, {27'd0, tbl[v].idx});
            if (tbl[v].chg1) chk($sformatf("t%0d_ix1", v), {27'd0, ix1}, {27'd0, tbl[v].idx});
            tick;
            chk($sformatf("t%0d_pulse_end", v), {28'd0, ch0, ch1, pe0, pe1}, 32'd0);
        end

        // Move during pause is held until release.
        e_pause_qb  = 1'b1;
        position_qb = 28'h0000008;
        done_move   = 1'b1;
        tick;
        done_move   = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (ch0 || ch1 || cs0 != 28'h8000021) seen = 1;
        end
        chk("pause_hold", {31'd0, seen}, 32'd0);
        e_pause_qb = 1'b0;
        tick; tick; tick;
        chk("pause_early", {4'd0, cs0}, 32'h8000021);
        tick;
        chk("pause_cs0", {4'd0, cs0}, 32'h8000029);
        chk("pause_cs1", {4'd0, cs1}, 32'h8000009);
        chk("pause_ch", {30'd0, ch0, ch1}, 32'd3);
        chk("pause_ix", {27'd0, ix0}, 32'd3);

        // Start during DELAY abandons the pending landing.
        position_qb = 28'h0000400;
        done_move   = 1'b1;
        tick;
        done_move   = 1'b0;
        pulse_start;
        chk("sd_cs0", {4'd0, cs0}, 32'd0);
        chk("sd_lc0", {27'd0, lc0}, 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (ch0 || ch1 || cs0 != 0 || cs1 != 0) seen = 1;
        end
        chk("sd_dropped", {31'd0, seen}, 32'd0);

        // Reset during APPLY.
        move(28'h0000004, 0);
        chk("ra_pre", {27'd0, lc0}, 32'd1);
        position_qb = 28'h0000010;
        done_move   = 1'b1;
        tick;
        done_move   = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("ra_cs", {4'd0, cs0 | cs1}, 32'd0);
        chk("ra_lc", {22'd0, lc0, lc1}, 32'd0);
        chk("ra_flags", {26'd0, ch0, ch1, w0, w1, pe0, pe1}, 32'd0);
        chk("ra_ix", {22'd0, ix0, ix1}, 32'd0);
        tick; tick;
        chk("ra_after", {4'd0, cs0 | cs1}, 32'd0);

        // Start coincident with done_move: the move is dropped.
        position_qb = 28'h0000001;
        e_start_qb  = 1'b1;
        done_move   = 1'b1;
        tick;
        e_start_qb  = 1'b0;
        done_move   = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (ch0 || ch1 || cs0 != 0) seen = 1;
        end
        chk("coinc_dropped", {31'd0, seen}, 32'd0);

        // Visit every cube; both modes reach win.
        for (int i = 0; i < 28; i++) begin
            p = 28'd1 << i;
            move(p, 0);
            chk($sformatf("win_ch0_%0d", i), {31'd0, ch0}, 32'd1);
        end
        chk("win_lc0", {27'd0, lc0}, 32'd28);
        chk("win_lc1", {27'd0, lc1}, 32'd28);
        chk("win_flags", {30'd0, w0, w1}, 32'd3);
        chk("win_cs0", {4'd0, cs0}, 32'h0FFFFFFF);
        move(28'h0000001, 0);
        chk("win_frozen", {4'd0, cs1}, 32'h0FFFFFFF);
        chk("win_nochg", {30'd0, ch0, ch1}, 32'd0);
        chk("win_hold", {30'd0, w0, w1}, 32'd3);
        pulse_start;
        chk("win_clr_w", {30'd0, w0, w1}, 32'd0);
        chk("win_clr_cs", {4'd0, cs0 | cs1}, 32'd0);

        // Randomised landings against the model, with occasional dropped moves and bad positions.
        model_clear;
        for (int n = 0; n < 150; n++) begin
            int r;
            bit extra;
            r = int'($urandom_range(0, 9));
            if (r == 0) p = '0;
            else if (r == 1) p = (28'd1 << $urandom_range(0, 27)) | (28'd1 << $urandom_range(0, 27));
            else p = 28'd1 << $urandom_range(0, 27);
            extra = ($urandom_range(0, 3) == 0);
            move(p, extra);
            model_land(p);
            chk_model;
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cube_color_tracker.md
# cube_color_tracker

Upstream stage of the map colouring layer. Tracks which of the 28 pyramid cubes have had their top face changed by Q*bert, and produces the `e_color_state` vector the map colouring layer uses to choose the top-face colour. It also produces a lit-cube count, a per-landing change pulse for scoring, and a win flag. It consumes `done_move` and the one-hot `position_qb` vector from the map/position logic, and honours the game start and pause controls.

## Interface
- `N_CUBE`, 28: number of cubes; this is the width of the position and colour vectors.
- `MODE`, 0: 0 = set-only (a landing lights the cube, and it stays lit); 1 = toggle (a landing flips the cube).
- `SAMPLE_DLY`, 2: cycles waited after `done_move` before sampling `position_qb`; legal range 1..15.

Ports:
- `CLK_33`  in  1  pixel/system clock.
- `reset`  in  1  synchronous, active-high; one clock, `CLK_33`.
- `e_start_qb`  in  1  single-cycle pulse: clear the board and start a level.
- `e_pause_qb`  in  1  level: game paused.
- `done_move`  in  1  single-cycle pulse: Q*bert finished a jump.
- `position_qb`  in  N_CUBE  one-hot cube under Q*bert; lags Q*bert's coordinates by 2 cycles.
- `color_state`  out  N_CUBE  bit i = 1 means the top face of cube i is the target colour.
- `lit_count`  out  5  number of set bits in `color_state`, from 0 to 28.
- `cube_changed`  out  1  single-cycle pulse when a landing changed a cube.
- `cube_idx`  out  5  index of the changed cube; valid while `cube_changed` = 1.
- `win`  out  1  level: all cubes are lit.
- `pos_err`  out  1  single-cycle pulse: `position_qb` was not one-hot when sampled.

## Operation
- States: IDLE, RUN, DELAY, APPLY, WIN. `reset` forces IDLE.
- Reset values: `color_state` = 0, `lit_count` = 0, `win` = 0, `cube_changed` = 0, `cube_idx` = 0, `pos_err` = 0, `pend` = 0, delay counter = 0.
- `e_start_qb` is accepted in every state and has priority over all other events:
  - `color_state` and `lit_count` are cleared; `win` and `pend` are cleared.
  - Next state is RUN. Any DELAY or APPLY in progress is abandoned.
- IDLE: `done_move` is ignored.
- RUN:
  - `done_move` with `e_pause_qb` = 0: load the counter with `SAMPLE_DLY` and go to DELAY.
  - `done_move` with `e_pause_qb` = 1: set `pend`.
  - `pend` = 1 and `e_pause_qb` = 0: clear `pend`, load the counter, go to DELAY.
- DELAY: decrement the counter every cycle, including while paused. When the counter reaches 1, go to APPLY.
- APPLY: sample `position_qb`.
  - Not one-hot (zero bits or several bits set): pulse `pos_err`; no change; return to RUN.
  - One-hot with bit i set:
    - MODE 0, cube i unlit: set bit i, increment `lit_count`, pulse `cube_changed` with `cube_idx` = i.
    - MODE 0, cube i already lit: no change and no pulse.
    - MODE 1: flip bit i, increment or decrement `lit_count` accordingly, pulse `cube_changed` with `cube_idx` = i.
  - If the updated `lit_count` equals `N_CUBE`: set `win` and go to WIN. Otherwise return to RUN.
- WIN: `color_state` is frozen and `done_move` is ignored. Only `e_start_qb` or `reset` leaves WIN.
- A `done_move` arriving in DELAY or APPLY is dropped; it is not queued.
- Width rules:
  - `lit_count` never wraps: it saturates at 0 on decrement and at `N_CUBE` on increment. These limits are unreachable in correct operation.
  - `cube_idx` holds the binary encoding of the one-hot position.

## Timing
- `done_move` at cycle t, RUN, not paused:
  - DELAY occupies cycles t+1 … t+SAMPLE_DLY.
  - APPLY samples `position_qb` at t+SAMPLE_DLY+1.
  - `color_state`, `lit_count`, `cube_changed`, `cube_idx`, `pos_err` and `win` update at t+SAMPLE_DLY+2.
  - Default total latency: 4 cycles.
- A pending move released when `e_pause_qb` falls at cycle p: DELAY starts at p+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `e_start_qb` at cycle s: cleared outputs are visible at s+1.
- `e_start_qb` coincident with `done_move`: the start wins and the move is dropped.

## Test plan
- Reset, then `e_start_qb`, then `done_move` with `position_qb` = 28'h0000001 (MODE 0) → 4 cycles later `color_state` = 1, `lit_count` = 1, a 1-cycle `cube_changed` with `cube_idx` = 0.
- Land twice on cube 5:
  - MODE 0 → second landing gives no change and no `cube_changed`.
  - MODE 1 → `color_state` bit 5 returns to 0 and `lit_count` returns to 0.
- `done_move` while `e_pause_qb` = 1, pause held 10 cycles with `position_qb` = bit 3 → no update while paused; update at release+SAMPLE_DLY+2.
- Sample `position_qb` = 0, then 28'h0000003 → `pos_err` pulses each time; `color_state` unchanged.
- Visit all 28 cubes in MODE 0 → `lit_count` = 28 and `win` = 1. A further `done_move` gives no change. `e_start_qb` → `win` = 0 and `color_state` = 0 next cycle.
- `e_start_qb` during DELAY, and `reset` during APPLY → the pending update is never applied and all outputs read their cleared values.
